// File: rtl/elevator_pkg.sv
// -----------------------------------------------------------------------------
// elevator_pkg
// Shared types and constants for the three-floor elevator controller and its
// display-side consumers.
//   state_t        : controller FSM states
//   FLOOR1..FLOOR3 : 2-bit floor codes as seen on {i1,i0}
//   floor_onehot() : floor code -> request-vector bit (bit 1 = floor 1)
// -----------------------------------------------------------------------------
package elevator_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    MOVE_UP   = 2'd1,
    MOVE_DOWN = 2'd2,
    DOOR      = 2'd3
  } state_t;

  localparam logic [1:0] FLOOR1 = 2'b01;
  localparam logic [1:0] FLOOR2 = 2'b10;
  localparam logic [1:0] FLOOR3 = 2'b11;

  // Maps a floor code onto the request vector req[3:1].
  function automatic logic [3:1] floor_onehot(input logic [1:0] floor);
    floor_onehot = 3'b000;
    case (floor)
      FLOOR1:  floor_onehot = 3'b001;
      FLOOR2:  floor_onehot = 3'b010;
      FLOOR3:  floor_onehot = 3'b100;
      default: floor_onehot = 3'b000;
    endcase
  endfunction

endpackage

// File: rtl/elevator_tick_timer.sv
// -----------------------------------------------------------------------------
// elevator_tick_timer
// Counts 0..TICKS-1 while enabled and pulses done on the last count, then wraps
// to zero so back-to-back intervals need no extra clear cycle.
// Ports:
//   clock, reset_n : clock and synchronous active-low reset
//   clear          : force the count to zero (highest priority)
//   load/load_value: preset the count (e.g. to shorten an interval)
//   en             : advance the count this cycle
//   done           : combinational, high in the final cycle of an interval
// -----------------------------------------------------------------------------
module elevator_tick_timer #(
  parameter int WIDTH = 3,
  parameter int TICKS = 8
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             clear,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  input  logic             en,
  output logic             done
);

  localparam logic [WIDTH-1:0] LAST = WIDTH'(TICKS - 1);

  logic [WIDTH-1:0] count_q, count_d;

  always_comb begin
    done    = en && (count_q == LAST);
    count_d = count_q;
    if (clear || done) begin
      count_d = '0;
    end else if (load) begin
      count_d = load_value;
    end else if (en) begin
      count_d = count_q + WIDTH'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/elevator_controller_3f.sv
// -----------------------------------------------------------------------------
// elevator_controller_3f
// Three-floor elevator controller: latches call buttons, moves the cabin one
// floor per TRAVEL_TICKS cycles, holds the door for DOOR_TICKS cycles, and
// drives the floor code / blink flag for the display controller.
// Ports:
//   clock, reset_n        : clock, synchronous active-low reset
//   b1, b2, b3            : call buttons for floors 1..3
//   i1, i0                : floor code (01/10/11), never 00
//   ip                    : blink request, high while moving
//   motor_up, motor_down  : travel direction (mutually exclusive)
//   door_open             : door open
// -----------------------------------------------------------------------------
module elevator_controller_3f
  import elevator_pkg::*;
#(
  parameter int TRAVEL_TICKS = 8,
  parameter int DOOR_TICKS   = 6
) (
  input  logic clock,
  input  logic reset_n,
  input  logic b1,
  input  logic b2,
  input  logic b3,
  output logic i0,
  output logic i1,
  output logic ip,
  output logic motor_up,
  output logic motor_down,
  output logic door_open
);

  localparam int TW = (TRAVEL_TICKS > 2) ? $clog2(TRAVEL_TICKS) : 1;
  localparam int DW = (DOOR_TICKS > 2) ? $clog2(DOOR_TICKS) : 1;

  state_t     state_q, state_d;
  logic [1:0] floor_q, floor_d;
  logic [3:1] req_q, req_d;
  logic       last_up_q, last_up_d;
  logic       ip_q, ip_d, up_q, up_d, down_q, down_d, door_q, door_d;

  logic [3:1] buttons, clr_mask;
  logic       in_move, in_door, travel_done, door_done, door_entry;
  logic       req_here, req_above, req_below;
  logic [1:0] floor_up, floor_down;

  assign buttons = {b3, b2, b1};
  assign in_move = (state_q == MOVE_UP) || (state_q == MOVE_DOWN);
  assign in_door = (state_q == DOOR);

  elevator_tick_timer #(.WIDTH(TW), .TICKS(TRAVEL_TICKS)) u_travel_timer (
    .clock      (clock),
    .reset_n    (reset_n),
    .clear      (!in_move),
    .load       (1'b0),
    .load_value ('0),
    .en         (in_move),
    .done       (travel_done)
  );

  elevator_tick_timer #(.WIDTH(DW), .TICKS(DOOR_TICKS)) u_door_timer (
    .clock      (clock),
    .reset_n    (reset_n),
    .clear      (!in_door),
    .load       (1'b0),
    .load_value ('0),
    .en         (in_door),
    .done       (door_done)
  );

  assign req_here  = |(req_q & floor_onehot(floor_q));
  assign req_above = (floor_q == FLOOR1) ? |req_q[3:2] :
                     (floor_q == FLOOR2) ? req_q[3] : 1'b0;
  assign req_below = (floor_q == FLOOR3) ? |req_q[2:1] :
                     (floor_q == FLOOR2) ? req_q[1] : 1'b0;

  // Saturating neighbours keep the floor code inside 01..11.
  assign floor_up   = (floor_q == FLOOR3) ? FLOOR3 : floor_q + 2'd1;
  assign floor_down = (floor_q == FLOOR1) ? FLOOR1 : floor_q - 2'd1;

  always_comb begin
    state_d    = state_q;
    floor_d    = floor_q;
    last_up_d  = last_up_q;
    door_entry = 1'b0;
    case (state_q)
      IDLE: begin
        if (req_here) begin
          state_d    = DOOR;
          door_entry = 1'b1;
        end else if (last_up_q && req_above) begin
          state_d   = MOVE_UP;
          last_up_d = 1'b1;
        end else if (req_below) begin
          state_d   = MOVE_DOWN;
          last_up_d = 1'b0;
        end else if (req_above) begin
          state_d   = MOVE_UP;
          last_up_d = 1'b1;
        end
      end
      MOVE_UP: begin
        if (travel_done) begin
          floor_d = floor_up;
          if (|(req_q & floor_onehot(floor_up))) begin
            state_d    = DOOR;
            door_entry = 1'b1;
          end
        end
      end
      MOVE_DOWN: begin
        if (travel_done) begin
          floor_d = floor_down;
          if (|(req_q & floor_onehot(floor_down))) begin
            state_d    = DOOR;
            door_entry = 1'b1;
          end
        end
      end
      DOOR: begin
        if (door_done) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // Outputs are decoded from the next state so they flip on the same edge
    // as the state itself.
    ip_d   = (state_d == MOVE_UP) || (state_d == MOVE_DOWN);
    up_d   = (state_d == MOVE_UP);
    down_d = (state_d == MOVE_DOWN);
    door_d = (state_d == DOOR);
  end

  // Per-floor request bits: a press sets, arrival (door entry) clears, and a
  // press for the floor whose door is already open is swallowed.
  for (genvar gi = 1; gi <= 3; gi++) begin : g_req
    assign clr_mask[gi] = (door_entry && (floor_d == 2'(gi))) ||
                          (in_door && (floor_q == 2'(gi)));
    assign req_d[gi]    = (req_q[gi] | buttons[gi]) & ~clr_mask[gi];
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      floor_q   <= FLOOR1;
      req_q     <= '0;
      last_up_q <= 1'b1;
      ip_q      <= 1'b0;
      up_q      <= 1'b0;
      down_q    <= 1'b0;
      door_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      floor_q   <= floor_d;
      req_q     <= req_d;
      last_up_q <= last_up_d;
      ip_q      <= ip_d;
      up_q      <= up_d;
      down_q    <= down_d;
      door_q    <= door_d;
    end
  end

  assign i0         = floor_q[0];
  assign i1         = floor_q[1];
  assign ip         = ip_q;
  assign motor_up   = up_q;
  assign motor_down = down_q;
  assign door_open  = door_q;

endmodule

// File: tb/tb_elevator_controller_3f.sv
// -----------------------------------------------------------------------------
// tb_elevator_controller_3f
// Directed scenarios for the three-floor elevator controller with a cycle-level
// reference model of the cabin (floor number, pending calls, activity and the
// cycles spent in it) plus hand-computed spot checks at key edges.
// -----------------------------------------------------------------------------
module tb_elevator_controller_3f;

  localparam int TRAVEL = 4;
  localparam int DWELL  = 3;

  localparam int M_IDLE = 0;
  localparam int M_UP   = 1;
  localparam int M_DOWN = 2;
  localparam int M_DOOR = 3;

  logic clock = 1'b0;
  logic reset_n, b1, b2, b3;
  logic i0, i1, ip, motor_up, motor_down, door_open;

  int errors = 0;
  int checks = 0;
  bit cmp_en = 1'b0;

  // Reference model
  int       m_floor;
  bit [3:1] m_req;
  int       m_mode;
  int       m_elapsed;
  bit       m_last_up;

  elevator_controller_3f #(.TRAVEL_TICKS(TRAVEL), .DOOR_TICKS(DWELL)) dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .b1         (b1),
    .b2         (b2),
    .b3         (b3),
    .i0         (i0),
    .i1         (i1),
    .ip         (ip),
    .motor_up   (motor_up),
    .motor_down (motor_down),
    .door_open  (door_open)
  );

  always #5 clock = ~clock;

  function automatic bit any_above(input bit [3:1] r, input int f);
    any_above = 1'b0;
    for (int k = f + 1; k <= 3; k++) if (r[k]) any_above = 1'b1;
  endfunction

  function automatic bit any_below(input bit [3:1] r, input int f);
    any_below = 1'b0;
    for (int k = 1; k < f; k++) if (r[k]) any_below = 1'b1;
  endfunction

  // Model advances on every rising edge using the inputs present at that edge.
  always @(posedge clock) begin
    int       old_floor;
    int       old_mode;
    bit       entered;
    bit [3:1] r;
    if (!reset_n) begin
      m_floor   = 1;
      m_req     = '0;
      m_mode    = M_IDLE;
      m_elapsed = 0;
      m_last_up = 1'b1;
    end else begin
      old_floor = m_floor;
      old_mode  = m_mode;
      entered   = 1'b0;
      r         = m_req;
      case (m_mode)
        M_IDLE: begin
          m_elapsed = 0;
          if (r[m_floor]) begin
            m_mode = M_DOOR; entered = 1'b1;
          end else if (m_last_up && any_above(r, m_floor)) begin
            m_mode = M_UP;
          end else if (any_below(r, m_floor)) begin
            m_mode = M_DOWN; m_last_up = 1'b0;
          end else if (any_above(r, m_floor)) begin
            m_mode = M_UP; m_last_up = 1'b1;
          end
        end
        M_UP, M_DOWN: begin
          m_elapsed++;
          if (m_elapsed == TRAVEL) begin
            m_elapsed = 0;
            m_floor   = (m_mode == M_UP) ? m_floor + 1 : m_floor - 1;
            if (r[m_floor]) begin
              m_mode = M_DOOR; entered = 1'b1;
            end
          end
        end
        default: begin
          m_elapsed++;
          if (m_elapsed == DWELL) begin
            m_mode = M_IDLE; m_elapsed = 0;
          end
        end
      endcase
      r = r | {b3, b2, b1};
      if (old_mode == M_DOOR) r[old_floor] = 1'b0;
      if (entered) r[m_floor] = 1'b0;
      m_req = r;
    end
  end

  // Every-cycle comparison of all outputs against the model.
  always @(negedge clock) begin
    logic [5:0] act, exp;
    if (cmp_en) begin
      act = {i1, i0, ip, motor_up, motor_down, door_open};
      exp = {2'(m_floor), (m_mode == M_UP) || (m_mode == M_DOWN),
             m_mode == M_UP, m_mode == M_DOWN, m_mode == M_DOOR};
      checks++;
      if (act !== exp) begin
        errors++;
        $display("FAIL model_cycle t=%0t: {i1,i0,ip,up,down,door} got %b expected %b",
                 $time, act, exp);
      end
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string name, input logic [1:0] act, input logic [1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  initial begin
    reset_n = 1'b0; b1 = 1'b0; b2 = 1'b0; b3 = 1'b0;

    // Reset held for two cycles
    tick(); cmp_en = 1'b1; tick();
    chk("reset_code", {i1, i0}, 2'b01);
    chk("reset_motor", {motor_up, motor_down}, 2'b00);
    chk("reset_ip_door", {ip, door_open}, 2'b00);
    reset_n = 1'b1;
    repeat (2) tick();
    chk("idle_quiet", {ip, door_open}, 2'b00);
    $display("txn reset: code=%b%b", i1, i0);

    // b1 held at floor 1: door after one cycle, presses during dwell ignored
    b1 = 1'b1;
    tick(); tick();
    chk("b1_door_open", {door_open, ip}, 2'b10);
    chk("b1_code", {i1, i0}, 2'b01);
    repeat (2) tick();
    chk("b1_door_held", {door_open, motor_up}, 2'b10);
    b1 = 1'b0;
    tick();
    chk("b1_door_closed", {door_open, ip}, 2'b00);
    repeat (2) tick();
    chk("b1_no_reopen", {door_open, ip}, 2'b00);
    $display("txn b1_at_floor1: code=%b%b door=%b", i1, i0, door_open);

    // One-cycle b3 pulse from floor 1
    b3 = 1'b1; tick(); b3 = 1'b0;
    chk("b3_not_yet", {motor_up, ip}, 2'b00);
    tick();
    chk("b3_moving", {motor_up, ip}, 2'b11);
    repeat (3) tick();
    chk("b3_still_f1", {i1, i0}, 2'b01);
    tick();
    chk("b3_at_f2", {i1, i0}, 2'b10);
    chk("b3_passing_f2", {motor_up, door_open}, 2'b10);
    repeat (4) tick();
    chk("b3_at_f3", {i1, i0}, 2'b11);
    chk("b3_door", {door_open, motor_up}, 2'b10);
    repeat (2) tick();
    chk("b3_door_last", {door_open, ip}, 2'b10);
    tick();
    chk("b3_door_closed", {door_open, ip}, 2'b00);
    repeat (3) tick();
    chk("b3_idle", {i1, i0}, 2'b11);
    $display("txn b3_pulse: code=%b%b", i1, i0);

    // Reset from floor 3, then go to floor 2 going up (last_up = 1)
    reset_n = 1'b0; tick(); reset_n = 1'b1;
    chk("rst_f3_code", {i1, i0}, 2'b01);
    b2 = 1'b1; tick(); b2 = 1'b0;
    repeat (5) tick();
    chk("to_f2", {i1, i0}, 2'b10);
    chk("to_f2_door", {door_open, ip}, 2'b10);
    repeat (4) tick();
    $display("txn go_to_f2: code=%b%b", i1, i0);

    // At floor 2: b1 and b3 together, up first then down
    b1 = 1'b1; b3 = 1'b1; tick(); b1 = 1'b0; b3 = 1'b0;
    tick();
    chk("both_up_first", {motor_up, motor_down}, 2'b10);
    repeat (4) tick();
    chk("both_at_f3", {i1, i0}, 2'b11);
    chk("both_f3_door", {door_open, ip}, 2'b10);
    repeat (3) tick();
    chk("both_f3_closed", {door_open, motor_down}, 2'b00);
    tick();
    chk("both_down", {motor_up, motor_down}, 2'b01);
    repeat (4) tick();
    chk("both_pass_f2", {i1, i0}, 2'b10);
    chk("both_pass_f2_mot", {motor_down, door_open}, 2'b10);
    repeat (4) tick();
    chk("both_at_f1", {i1, i0}, 2'b01);
    chk("both_f1_door", {door_open, ip}, 2'b10);
    repeat (4) tick();
    $display("txn both_calls: code=%b%b", i1, i0);

    // b2 pressed during 1->3 travel: intermediate stop
    b3 = 1'b1; tick(); b3 = 1'b0;
    tick();
    b2 = 1'b1; tick(); b2 = 1'b0;
    repeat (3) tick();
    chk("mid_stop_f2", {i1, i0}, 2'b10);
    chk("mid_stop_door", {door_open, ip}, 2'b10);
    repeat (3) tick();
    chk("mid_stop_closed", {door_open, ip}, 2'b00);
    tick();
    chk("mid_resume", {motor_up, motor_down}, 2'b10);
    repeat (4) tick();
    chk("mid_at_f3", {i1, i0}, 2'b11);
    chk("mid_f3_door", {door_open, ip}, 2'b10);
    repeat (4) tick();
    $display("txn mid_travel_call: code=%b%b", i1, i0);

    // Reset two cycles into MOVE_UP
    reset_n = 1'b0; tick(); reset_n = 1'b1;
    b3 = 1'b1; tick(); b3 = 1'b0;
    tick();
    repeat (2) tick();
    chk("rst_mv_moving", {motor_up, ip}, 2'b11);
    reset_n = 1'b0; tick(); reset_n = 1'b1;
    chk("rst_mv_code", {i1, i0}, 2'b01);
    chk("rst_mv_motor", {motor_up, ip}, 2'b00);
    repeat (12) tick();
    chk("rst_mv_no_move", {ip, door_open}, 2'b00);
    chk("rst_mv_final_code", {i1, i0}, 2'b01);
    $display("txn reset_mid_move: code=%b%b", i1, i0);

    cmp_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/elevator_controller_3f.md
# elevator_controller_3f

Three-floor elevator controller that latches hall/cabin call buttons, sequences the cabin between floors with timed travel and door dwell, and drives the floor code (`i0`, `i1`) and blink flag (`ip`) consumed by the seven-segment display controller. It sits upstream of the display controller and is the producer side of that 3-bit floor/blink interface. Motor and door outputs go to the top level.

## Interface
Parameters:
- `TRAVEL_TICKS`, 8: clock cycles to move one floor; legal range ≥ 2.
- `DOOR_TICKS`, 6: clock cycles the door stays open; legal range ≥ 2.

Ports:
- `clock`  in  1  system clock; all logic on the rising edge.
- `reset_n`  in  1  synchronous, active-low reset.
- `b1`, `b2`, `b3`  in  1 each  call buttons for floors 1..3; level or pulse; sampled every cycle.
- `i0`  out  1  floor code LSB. Codes: 01 = floor 1, 10 = floor 2, 11 = floor 3; 00 is never driven.
- `i1`  out  1  floor code MSB.
- `ip`  out  1  blink request; 1 while the cabin is moving.
- `motor_up`  out  1  cabin moving up.
- `motor_down`  out  1  cabin moving down; never 1 together with `motor_up`.
- `door_open`  out  1  door open.

## Operation
- **Request register `req[3:1]`**
  - Sets the bit for any pressed button.
  - Clears the bit for the current floor on entry to DOOR.
  - A press for the current floor while in DOOR is ignored.
  - Set and clear of the same bit in the same cycle: clear wins.
- **Floor register**
  - 2-bit value, 1..3, encoded directly as {`i1`,`i0`}.
  - Saturates: never decrements below 1 or increments above 3.
- **Direction flag `last_up`**: records the most recent travel direction; reset value 1.
- **FSM states and transitions**
  - IDLE
    - Request at the current floor → DOOR.
    - Else, if `last_up` and any request above → MOVE_UP.
    - Else, any request below → MOVE_DOWN.
    - Else, any request above → MOVE_UP.
    - Else stay in IDLE.
  - MOVE_UP / MOVE_DOWN
    - Travel counter runs 0..`TRAVEL_TICKS`-1.
    - On the terminal count, floor ±1 and the counter clears.
    - If the new floor has a request → DOOR.
    - Otherwise continue in the same direction. A further request is guaranteed to exist because the direction was chosen toward it.
  - DOOR
    - Dwell counter runs 0..`DOOR_TICKS`-1.
    - On the terminal count → IDLE.
- **Outputs, all registered**
  - `ip` = 1 in MOVE_*.
  - `motor_up` = 1 in MOVE_UP.
  - `motor_down` = 1 in MOVE_DOWN.
  - `door_open` = 1 in DOOR.
- **Reset** (`reset_n` = 0 at a rising edge)
  - State = IDLE, floor = 1 ({`i1`,`i0`} = 01), `req` = 0, both counters = 0, `last_up` = 1.
  - `ip`, `motor_up`, `motor_down`, `door_open` = 0.
  - Reset in mid-travel or mid-dwell abandons the operation. The cabin is declared at floor 1 with no calls pending.

## Timing
- **Button to register:** a button sampled high at edge E sets `req` at E.
- **Register to FSM:** IDLE acts on `req` at E+1, so a move starts at E+1 with `motor_*` and `ip` high after E+1.
- **Single-floor move:** exactly `TRAVEL_TICKS` cycles in the MOVE state per floor.
- **Arrival edge:** the floor code updates on the same edge that enters DOOR or starts the next floor's count.
- **DOOR entry edge:** `ip` and `motor_*` drop, `door_open` rises, and the serviced `req` bit clears, all on one edge.
- **Door dwell:** exactly `DOOR_TICKS` cycles, then one IDLE cycle minimum before any new move or re-open.
- **Floor code stability:** the floor code changes only on arrival edges; it never glitches through 00.

## Structure
- **Shared package `elevator_pkg`:**
  - State enum: IDLE, MOVE_UP, MOVE_DOWN, DOOR.
  - Floor-code constants: FLOOR1 = 2'b01, FLOOR2 = 2'b10, FLOOR3 = 2'b11.
  - These are reused by the display controller bench.
- **Sub-module `elevator_tick_timer`:**
  - Parameterised width, with load/clear and a `done` pulse.
  - Instantiated twice: travel timer and door timer.

## Test plan
Parameters: `TRAVEL_TICKS` = 4, `DOOR_TICKS` = 3.
- **Reset:** `reset_n` = 0 for 2 cycles → {`i1`,`i0`} = 01; `ip`, `motor_*`, `door_open` = 0.
- **One-cycle `b3` pulse from floor 1:**
  - `motor_up` = `ip` = 1 from E+1.
  - Floor code 10 after 4 further cycles, 11 after 8.
  - `door_open` for 3 cycles, then IDLE with `req` = 0.
- **`b1` held while at floor 1 in IDLE:** DOOR entered after 1 cycle, no motor activity, floor code stays 01.
- **At floor 2, `b1` and `b3` pressed the same cycle, `last_up` = 1:**
  - Goes up first: 11 after 4 cycles, then door.
  - Then down to 01 after 8 cycles of MOVE_DOWN.
- **`b2` pressed while traveling 1→3:** cabin stops at floor 2 (door 3 cycles), then resumes up to 3.
- **Reset asserted 2 cycles into MOVE_UP:** next edge gives floor 01, `motor_up` = 0, `req` = 0; no spurious move afterwards.
